// File: rtl/tjmono_tx_pkg.sv
// Shared word layout, FSM state type and small helpers for the TJ-Monopix
// serial readout transmitter emulator.
package tjmono_tx_pkg;

  localparam int COL_W  = 6;
  localparam int ROW_W  = 9;
  localparam int TS_W   = 6;
  localparam int WORD_W = COL_W + ROW_W + 2 * TS_W;

  localparam int TE_LSB  = 0;
  localparam int LE_LSB  = TE_LSB + TS_W;
  localparam int ROW_LSB = LE_LSB + TS_W;
  localparam int COL_LSB = ROW_LSB + ROW_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SHIFT = 2'd2
  } tx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tjmono_data_tx_emu_gray_enc6.sv
// Combinational 6-bit binary to Gray code converter for hit timestamps.
module gray_enc6
  import tjmono_tx_pkg::*;
(
  input  logic [TS_W-1:0] bin,
  output logic [TS_W-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/tjmono_data_tx_emu.sv
// Chip-side emulator of the TJ-Monopix token/freeze/read serial readout:
// buffers hits, raises TOKEN, honours FREEZE and shifts one word per READ edge.
module tjmono_data_tx_emu
  import tjmono_tx_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TX_DLY  = 2,
  parameter bit GRAY_EN = 1'b1
) (
  input  logic       RX_CLK,
  input  logic       RST_N,
  input  logic       HIT_WR,
  input  logic [5:0] HIT_COL,
  input  logic [8:0] HIT_ROW,
  input  logic [5:0] HIT_LE,
  input  logic [5:0] HIT_TE,
  input  logic       READ,
  input  logic       FREEZE,
  output logic       TOKEN,
  output logic       DATA,
  output logic       BUSY,
  output logic [7:0] LOST_CNT,
  output logic [7:0] UNDERRUN_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [7:0]    DLY_LAST = 8'((TX_DLY >= 2) ? TX_DLY - 2 : 0);

  logic [TS_W-1:0] le_gray, te_gray, le_enc, te_enc;
  logic [WORD_W-1:0] hit_word, rd_word;

  logic read_s1_q, read_s2_q, read_s3_q;
  logic frz_s1_q, frz_s2_q, frz_s3_q;
  logic read_edge, frz_edge;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d, frz_cnt_q, frz_cnt_d;
  logic [7:0] lost_cnt_q, lost_cnt_d, underrun_cnt_q, underrun_cnt_d;
  logic token_q, token_d;

  tx_state_e state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] dly_cnt_q, dly_cnt_d;
  logic data_q, data_d, busy_q, busy_d;

  logic fifo_empty, fifo_full, pop, push, lost_evt, underrun_evt;

  gray_enc6 u_gray_le (.bin(HIT_LE), .gray(le_gray));
  gray_enc6 u_gray_te (.bin(HIT_TE), .gray(te_gray));

  assign le_enc   = GRAY_EN ? le_gray : HIT_LE;
  assign te_enc   = GRAY_EN ? te_gray : HIT_TE;
  assign hit_word = {HIT_COL, HIT_ROW, le_enc, te_enc};
  assign rd_word  = mem_q[rd_ptr_q];

  assign read_edge  = read_s2_q & ~read_s3_q;
  assign frz_edge   = frz_s2_q & ~frz_s3_q;
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == FULL_CNT);

  // READ edges arriving while a word is in flight fall through every branch.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    dly_cnt_d    = dly_cnt_q;
    data_d       = 1'b0;
    pop          = 1'b0;
    underrun_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (read_edge) begin
          pop          = !fifo_empty;
          underrun_evt = fifo_empty;
          shreg_d      = fifo_empty ? '0 : rd_word;
          dly_cnt_d    = '0;
          bit_cnt_d    = '0;
          if (TX_DLY == 1) begin
            state_d = ST_SHIFT;
            data_d  = shreg_d[WORD_W-1];
            shreg_d = {shreg_d[WORD_W-2:0], 1'b0};
          end else begin
            state_d = ST_DELAY;
          end
        end
      end
      ST_DELAY: begin
        if (dly_cnt_q == DLY_LAST) begin
          state_d   = ST_SHIFT;
          data_d    = shreg_q[WORD_W-1];
          shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
          bit_cnt_d = '0;
        end else begin
          dly_cnt_d = dly_cnt_q + 8'd1;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == 5'(WORD_W - 1)) begin
          state_d = ST_IDLE;
        end else begin
          data_d    = shreg_q[WORD_W-1];
          shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // A pop in the same cycle frees the slot, so a write at full is not lost.
  always_comb begin
    push           = HIT_WR && (!fifo_full || pop);
    lost_evt       = HIT_WR && fifo_full && !pop;
    wr_ptr_d       = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d       = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fifo_cnt_d     = fifo_cnt_q;
    if (push && !pop) fifo_cnt_d = fifo_cnt_q + CW'(1);
    if (pop && !push) fifo_cnt_d = fifo_cnt_q - CW'(1);
    lost_cnt_d     = lost_evt ? sat_inc8(lost_cnt_q) : lost_cnt_q;
    underrun_cnt_d = underrun_evt ? sat_inc8(underrun_cnt_q) : underrun_cnt_q;
    frz_cnt_d      = frz_cnt_q;
    if (frz_edge) begin
      frz_cnt_d = fifo_cnt_q - CW'(pop);
    end else if (pop && frz_s2_q && (frz_cnt_q != '0)) begin
      frz_cnt_d = frz_cnt_q - CW'(1);
    end
    token_d = frz_s2_q ? (frz_cnt_d != '0) : (fifo_cnt_d != '0);
  end

  always_ff @(posedge RX_CLK) begin
    if (push) mem_q[wr_ptr_q] <= hit_word;
  end

  always_ff @(posedge RX_CLK or negedge RST_N) begin
    if (!RST_N) begin
      read_s1_q      <= 1'b0;
      read_s2_q      <= 1'b0;
      read_s3_q      <= 1'b0;
      frz_s1_q       <= 1'b0;
      frz_s2_q       <= 1'b0;
      frz_s3_q       <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_cnt_q     <= '0;
      frz_cnt_q      <= '0;
      lost_cnt_q     <= '0;
      underrun_cnt_q <= '0;
      token_q        <= 1'b0;
      state_q        <= ST_IDLE;
      shreg_q        <= '0;
      bit_cnt_q      <= '0;
      dly_cnt_q      <= '0;
      data_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      read_s1_q      <= READ;
      read_s2_q      <= read_s1_q;
      read_s3_q      <= read_s2_q;
      frz_s1_q       <= FREEZE;
      frz_s2_q       <= frz_s1_q;
      frz_s3_q       <= frz_s2_q;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_cnt_q     <= fifo_cnt_d;
      frz_cnt_q      <= frz_cnt_d;
      lost_cnt_q     <= lost_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
      token_q        <= token_d;
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      bit_cnt_q      <= bit_cnt_d;
      dly_cnt_q      <= dly_cnt_d;
      data_q         <= data_d;
      busy_q         <= busy_d;
    end
  end

  assign TOKEN        = token_q;
  assign DATA         = data_q;
  assign BUSY         = busy_q;
  assign LOST_CNT     = lost_cnt_q;
  assign UNDERRUN_CNT = underrun_cnt_q;

endmodule
